gs232c_alloc_first_n: RTL and testbench



---
 rtl/gs232c_alloc_first_n_pkg.sv | 7 +
 rtl/gs232c_ffs_rot_n.sv | 31 +++
 rtl/gs232c_alloc_first_n.sv | 102 ++++++++++
 tb/tb_gs232c_alloc_first_n.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/gs232c_alloc_first_n_pkg.sv
// Shared definitions for the gs232c entry allocator.
package gs232c_alloc_first_n_pkg;

  localparam int unsigned RR_LOWEST = 0;
  localparam int unsigned RR_ROTATE = 1;

endpackage

// File: rtl/gs232c_ffs_rot_n.sv
// Combinational first-set search over a 2^N bit vector, starting at ptr_i and wrapping.
module gs232c_ffs_rot_n #(
  parameter int unsigned N = 3
) (
  input  logic [(1<<N)-1:0] vec_i,
  input  logic [N-1:0]      ptr_i,
  output logic [N-1:0]      idx_o,
  output logic              found_o
);

  localparam int unsigned ENTRIES = 1 << N;

  logic [2*ENTRIES-1:0] dbl;
  logic [2*ENTRIES-1:0] sh;
  logic [ENTRIES-1:0]   rot;
  logic [N-1:0]         off;

  // Rotate so the start pointer lands on bit 0, then a plain lowest-set search applies.
  always_comb begin
    dbl = {vec_i, vec_i};
    sh  = dbl >> ptr_i;
    rot = sh[ENTRIES-1:0];
    off = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (rot[ENTRIES-1-i]) off = N'(ENTRIES-1-i);
    end
    idx_o   = ptr_i + off;
    found_o = |vec_i;
  end

endmodule

// File: rtl/gs232c_alloc_first_n.sv
// Single-cycle entry allocator: free bitmap, registered next-grant index, release and flush.
module gs232c_alloc_first_n
  import gs232c_alloc_first_n_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned RR = RR_LOWEST
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              alloc_req,
  output logic              alloc_vld,
  output logic [N-1:0]      alloc_idx,
  input  logic              rel_vld,
  input  logic [N-1:0]      rel_idx,
  input  logic              flush,
  output logic [(1<<N)-1:0] free_map,
  output logic [N:0]        free_cnt,
  output logic              rel_err
);

  localparam int unsigned ENTRIES = 1 << N;

  logic [ENTRIES-1:0] free_map_q, nmap;
  logic [N:0]         free_cnt_q, free_cnt_d;
  logic               alloc_vld_q, alloc_vld_d;
  logic [N-1:0]       alloc_idx_q, alloc_idx_d;
  logic               rel_err_q, rel_err_d;
  logic [N-1:0]       ptr_q, ptr_d;

  logic               grant;
  logic               rel_hit;
  logic [ENTRIES-1:0] grant_oh, rel_oh;
  logic [N-1:0]       search_start;
  logic [N-1:0]       ffs_idx;
  logic               ffs_found;

  always_comb begin
    grant    = alloc_req & alloc_vld_q;
    rel_hit  = free_map_q[rel_idx];
    grant_oh = '0;
    rel_oh   = '0;
    if (grant) grant_oh[alloc_idx_q] = 1'b1;
    if (rel_vld && !rel_hit) rel_oh[rel_idx] = 1'b1;

    if (flush) begin
      nmap      = '1;
      ptr_d     = '0;
      rel_err_d = 1'b0;
    end else begin
      nmap      = (free_map_q & ~grant_oh) | rel_oh;
      ptr_d     = grant ? alloc_idx_q + N'(1) : ptr_q;
      rel_err_d = rel_vld & rel_hit;
    end
  end

  always_comb begin
    free_cnt_d = '0;
    for (int unsigned k = 0; k < ENTRIES; k++) begin
      free_cnt_d = free_cnt_d + (N+1)'(nmap[k]);
    end
  end

  // Search uses the post-update pointer so the next grant starts one past this one.
  assign search_start = (RR == RR_ROTATE) ? ptr_d : '0;

  gs232c_ffs_rot_n #(.N(N)) u_ffs (
    .vec_i   (nmap),
    .ptr_i   (search_start),
    .idx_o   (ffs_idx),
    .found_o (ffs_found)
  );

  always_comb begin
    alloc_vld_d = ffs_found;
    alloc_idx_d = ffs_found ? ffs_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      free_map_q  <= '1;
      free_cnt_q  <= (N+1)'(ENTRIES);
      alloc_vld_q <= 1'b1;
      alloc_idx_q <= '0;
      rel_err_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      free_map_q  <= nmap;
      free_cnt_q  <= free_cnt_d;
      alloc_vld_q <= alloc_vld_d;
      alloc_idx_q <= alloc_idx_d;
      rel_err_q   <= rel_err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign free_map  = free_map_q;
  assign free_cnt  = free_cnt_q;
  assign alloc_vld = alloc_vld_q;
  assign alloc_idx = alloc_idx_q;
  assign rel_err   = rel_err_q;

endmodule

// File: tb/tb_gs232c_alloc_first_n.sv
// Bench for gs232c_alloc_first_n: one lowest-first and one round-robin instance, N=3.
module tb_gs232c_alloc_first_n;

  logic       clk = 1'b0;
  logic       resetn;
  logic       alloc_req;
  logic       rel_vld;
  logic [2:0] rel_idx;
  logic       flush;

  logic       vld0, vld1, err0, err1;
  logic [2:0] idx0, idx1;
  logic [7:0] map0, map1;
  logic [3:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gs232c_alloc_first_n #(.N(3), .RR(0)) u0 (
    .clk(clk), .resetn(resetn), .alloc_req(alloc_req), .alloc_vld(vld0), .alloc_idx(idx0),
    .rel_vld(rel_vld), .rel_idx(rel_idx), .flush(flush), .free_map(map0), .free_cnt(cnt0),
    .rel_err(err0)
  );

  gs232c_alloc_first_n #(.N(3), .RR(1)) u1 (
    .clk(clk), .resetn(resetn), .alloc_req(alloc_req), .alloc_vld(vld1), .alloc_idx(idx1),
    .rel_vld(rel_vld), .rel_idx(rel_idx), .flush(flush), .free_map(map1), .free_cnt(cnt1),
    .rel_err(err1)
  );

  typedef struct {
    logic       rst_n;
    logic       req;
    logic       rv;
    logic [2:0] ri;
    logic       fl;
    logic       sel;   // 0: lowest-first instance, 1: round-robin instance
    logic [7:0] map;
    logic       vld;
    logic [2:0] idx;
    logic       err;
  } vec_t;

  vec_t sb[$];
  vec_t t0[17];
  vec_t t1[17];

  function automatic vec_t mk(input logic rst_n, input logic req, input logic rv,
                              input logic [2:0] ri, input logic fl, input logic sel,
                              input logic [7:0] map, input logic vld, input logic [2:0] idx,
                              input logic err);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.rv = rv; v.ri = ri; v.fl = fl; v.sel = sel;
    v.map = map; v.vld = vld; v.idx = idx; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %0h expected %0h", name, n, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    vec_t e;
    logic [3:0] ecnt;
    @(negedge clk);
    resetn = v.rst_n; alloc_req = v.req; rel_vld = v.rv; rel_idx = v.ri; flush = v.fl;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    ecnt = 4'($countones(e.map));
    if (!e.sel) begin
      chk("free_map0", n, 32'(map0), 32'(e.map));
      chk("free_cnt0", n, 32'(cnt0), 32'(ecnt));
      chk("alloc_vld0", n, 32'(vld0), 32'(e.vld));
      chk("alloc_idx0", n, 32'(idx0), 32'(e.idx));
      chk("rel_err0", n, 32'(err0), 32'(e.err));
    end else begin
      chk("free_map1", n, 32'(map1), 32'(e.map));
      chk("free_cnt1", n, 32'(cnt1), 32'(ecnt));
      chk("alloc_vld1", n, 32'(vld1), 32'(e.vld));
      chk("alloc_idx1", n, 32'(idx1), 32'(e.idx));
      chk("rel_err1", n, 32'(err1), 32'(e.err));
    end
  endtask

  initial begin
    // Lowest-first: drain, ignored request, release/grant overlap, bad release, flush, reset.
    t0[0]  = mk(1, 1, 0, 0, 0, 0, 8'hfe, 1, 1, 0);
    t0[1]  = mk(1, 1, 0, 0, 0, 0, 8'hfc, 1, 2, 0);
    t0[2]  = mk(1, 1, 0, 0, 0, 0, 8'hf8, 1, 3, 0);
    t0[3]  = mk(1, 1, 0, 0, 0, 0, 8'hf0, 1, 4, 0);
    t0[4]  = mk(1, 1, 0, 0, 0, 0, 8'he0, 1, 5, 0);
    t0[5]  = mk(1, 1, 0, 0, 0, 0, 8'hc0, 1, 6, 0);
    t0[6]  = mk(1, 1, 0, 0, 0, 0, 8'h80, 1, 7, 0);
    t0[7]  = mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    t0[8]  = mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    t0[9]  = mk(1, 0, 1, 5, 0, 0, 8'h20, 1, 5, 0);
    t0[10] = mk(1, 1, 1, 2, 0, 0, 8'h04, 1, 2, 0);
    t0[11] = mk(1, 0, 1, 6, 0, 0, 8'h44, 1, 2, 0);
    t0[12] = mk(1, 0, 1, 6, 0, 0, 8'h44, 1, 2, 1);
    t0[13] = mk(1, 0, 0, 0, 0, 0, 8'h44, 1, 2, 0);
    t0[14] = mk(1, 1, 1, 0, 1, 0, 8'hff, 1, 0, 0);
    t0[15] = mk(1, 1, 0, 0, 0, 0, 8'hfe, 1, 1, 0);
    t0[16] = mk(0, 1, 1, 1, 0, 0, 8'hff, 1, 0, 0);

    // Round-robin: search past a released low entry, wrap, then flush clears the pointer.
    t1[0]  = mk(0, 0, 0, 0, 0, 1, 8'hff, 1, 0, 0);
    t1[1]  = mk(1, 1, 0, 0, 0, 1, 8'hfe, 1, 1, 0);
    t1[2]  = mk(1, 1, 0, 0, 0, 1, 8'hfc, 1, 2, 0);
    t1[3]  = mk(1, 1, 0, 0, 0, 1, 8'hf8, 1, 3, 0);
    t1[4]  = mk(1, 0, 1, 0, 0, 1, 8'hf9, 1, 3, 0);
    t1[5]  = mk(1, 1, 0, 0, 0, 1, 8'hf1, 1, 4, 0);
    t1[6]  = mk(1, 1, 0, 0, 0, 1, 8'he1, 1, 5, 0);
    t1[7]  = mk(1, 1, 0, 0, 0, 1, 8'hc1, 1, 6, 0);
    t1[8]  = mk(1, 1, 0, 0, 0, 1, 8'h81, 1, 7, 0);
    t1[9]  = mk(1, 1, 0, 0, 0, 1, 8'h01, 1, 0, 0);
    t1[10] = mk(1, 1, 0, 0, 0, 1, 8'h00, 0, 0, 0);
    t1[11] = mk(1, 0, 1, 4, 0, 1, 8'h10, 1, 4, 0);
    t1[12] = mk(1, 1, 0, 0, 0, 1, 8'h00, 0, 0, 0);
    t1[13] = mk(1, 0, 1, 2, 0, 1, 8'h04, 1, 2, 0);
    t1[14] = mk(1, 1, 1, 3, 1, 1, 8'hff, 1, 0, 0);
    t1[15] = mk(1, 1, 0, 0, 0, 1, 8'hfe, 1, 1, 0);
    t1[16] = mk(1, 0, 1, 1, 0, 1, 8'hfe, 1, 1, 1);

    resetn = 1'b0; alloc_req = 1'b0; rel_vld = 1'b0; rel_idx = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_map0", -1, 32'(map0), 32'h0ff);
    chk("reset_cnt0", -1, 32'(cnt0), 32'd8);
    chk("reset_vld0", -1, 32'(vld0), 32'd1);
    chk("reset_idx0", -1, 32'(idx0), 32'd0);
    chk("reset_err0", -1, 32'(err0), 32'd0);
    chk("reset_map1", -1, 32'(map1), 32'h0ff);
    chk("reset_cnt1", -1, 32'(cnt1), 32'd8);
    chk("reset_vld1", -1, 32'(vld1), 32'd1);
    chk("reset_idx1", -1, 32'(idx1), 32'd0);
    chk("reset_err1", -1, 32'(err1), 32'd0);

    for (int i = 0; i < 17; i++) apply(t0[i], i);
    for (int i = 0; i < 17; i++) apply(t1[i], 100 + i);

    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
    end
    checks++;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
